// File: rtl/tdm_demultiplexer_pkg.sv
// Shared definitions for the TDM link: state encodings, default frame
// geometry and the slot-to-bitfield helper. Intended to be shared with the
// future TDM multiplexer transmitter.
package tdm_demultiplexer_pkg;

    // Framing FSM encodings (kept as fixed constants for legacy compatibility)
    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Default frame geometry
    localparam int unsigned DEF_N_CH = 4;
    localparam int unsigned DEF_W    = 8;

    // LSB position of a slot inside a packed channel bus
    function automatic int unsigned slot_lsb(input int unsigned slot,
                                             input int unsigned width);
        return slot * width;
    endfunction

endpackage

// File: rtl/tdm_demultiplexer_slot_counter.sv
// tdm_slot_counter: modulo-N_CH slot counter for the TDM framing logic.
//   clk, rst_n : clock, synchronous active-low reset
//   inc        : advance to the next slot (wraps N_CH-1 -> 0)
//   load1      : force the counter to 1 (slot 0 just consumed); wins over inc
//   cnt        : current slot index
//   last       : cnt == N_CH-1
module tdm_slot_counter
    import tdm_demultiplexer_pkg::*;
#(
    parameter int unsigned N_CH = DEF_N_CH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inc,
    input  logic                    load1,
    output logic [$clog2(N_CH)-1:0] cnt,
    output logic                    last
);

    localparam int unsigned CNT_W = $clog2(N_CH);

    // Explicit compare so non-power-of-2 N_CH wraps correctly
    assign last = (cnt == CNT_W'(N_CH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= CNT_W'(1);
        end else if (inc) begin
            if (last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tdm_demultiplexer.sv
// tdm_demultiplexer: receive end of a slot-interleaved TDM link. Slots are
// gathered into a shadow buffer and all channel outputs update together on
// the final slot of each frame.
//   clk, rst_n  : clock, synchronous active-low reset
//   din, en     : slot data and slot strobe (one slot per cycle with en=1)
//   sync        : frame marker, 1 on the slot-0 strobe
//   dout        : channel k at [k*W +: W], changes only on frame commit
//   frame_valid : one-cycle pulse when dout shows a new frame
//   locked      : framing established
//   sync_err    : one-cycle pulse on a framing violation
module tdm_demultiplexer
    import tdm_demultiplexer_pkg::*;
#(
    parameter int unsigned N_CH = DEF_N_CH,
    parameter int unsigned W    = DEF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      din,
    input  logic              en,
    input  logic              sync,
    output logic [N_CH*W-1:0] dout,
    output logic              frame_valid,
    output logic              locked,
    output logic              sync_err
);

    localparam int unsigned CNT_W = $clog2(N_CH);

    logic [0:0]       state;
    logic [W-1:0]     shadow [N_CH];
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             cnt_inc;
    logic             cnt_load1;

    // Any sync strobe (hunt or locked) makes the next slot 1; plain strobes
    // advance only mid-frame while locked.
    assign cnt_load1 = en && sync;
    assign cnt_inc   = en && !sync && (state == ST_LOCKED) && (cnt != '0);

    tdm_slot_counter #(
        .N_CH (N_CH)
    ) u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .load1 (cnt_load1),
        .cnt   (cnt),
        .last  (last)
    );

    assign locked = (state == ST_LOCKED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_HUNT;
            dout        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (en) begin
                if (state == ST_HUNT) begin
                    if (sync) begin
                        shadow[0] <= din;
                        state     <= ST_LOCKED;
                    end
                end else if (sync) begin
                    // Early sync drops the partial frame and restarts at slot 0
                    shadow[0] <= din;
                    if (cnt != '0) begin
                        sync_err <= 1'b1;
                    end
                end else if (cnt == '0) begin
                    // Missing sync: lose lock, keep dout
                    sync_err <= 1'b1;
                    state    <= ST_HUNT;
                end else begin
                    shadow[cnt] <= din;
                    if (last) begin
                        // Final slot bypasses the shadow straight into dout
                        for (int unsigned k = 0; k < N_CH - 1; k++) begin
                            dout[slot_lsb(k, W) +: W] <= shadow[CNT_W'(k)];
                        end
                        dout[slot_lsb(N_CH - 1, W) +: W] <= din;
                        frame_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demultiplexer.sv
module tb_tdm_demultiplexer;

    localparam int unsigned N_CH = 4;
    localparam int unsigned W    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [W-1:0]      din;
    logic              en;
    logic              sync;
    logic [N_CH*W-1:0] dout;
    logic              frame_valid;
    logic              locked;
    logic              sync_err;

    int n_checks = 0;
    int n_fail   = 0;

    tdm_demultiplexer #(
        .N_CH (N_CH),
        .W    (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .en          (en),
        .sync        (sync),
        .dout        (dout),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    // Reference model: frame assembled in a queue, committed when full
    bit         m_locked = 1'b0;
    logic [7:0] m_q[$];
    logic [31:0] m_dout = '0;
    bit         m_fv = 1'b0;
    bit         m_err = 1'b0;

    task automatic model_update(input logic r, input logic e, input logic s,
                                input logic [7:0] d);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (!r) begin
            m_locked = 1'b0;
            m_q.delete();
            m_dout = '0;
        end else if (e) begin
            if (!m_locked) begin
                if (s) begin
                    m_q.delete();
                    m_q.push_back(d);
                    m_locked = 1'b1;
                end
            end else if (s) begin
                if (m_q.size() != 0) m_err = 1'b1;
                m_q.delete();
                m_q.push_back(d);
            end else if (m_q.size() == 0) begin
                m_err    = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_q.push_back(d);
                if (m_q.size() == N_CH) begin
                    for (int i = 0; i < N_CH; i++) m_dout[i*8 +: 8] = m_q[i];
                    m_fv = 1'b1;
                    m_q.delete();
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic s,
                        input logic [7:0] d);
        rst_n = r;
        en    = e;
        sync  = s;
        din   = d;
        @(posedge clk);
        model_update(r, e, s, d);
        #1;
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic chk_model(input int idx);
        chk("dout",        idx, dout,               m_dout);
        chk("frame_valid", idx, 32'(frame_valid),   32'(m_fv));
        chk("locked",      idx, 32'(locked),        32'(m_locked));
        chk("sync_err",    idx, 32'(sync_err),      32'(m_err));
    endtask

    typedef struct {
        logic        r;
        logic        e;
        logic        s;
        logic [7:0]  d;
        logic [31:0] x_dout;
        logic        x_fv;
        logic        x_lk;
        logic        x_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic s, input logic [7:0] d,
                       input logic [31:0] xd, input logic xf, input logic xl, input logic xe);
        vec_t v;
        v.r = r; v.e = e; v.s = s; v.d = d;
        v.x_dout = xd; v.x_fv = xf; v.x_lk = xl; v.x_err = xe;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sync = 1'b0; din = '0;

        // Reset, clean frame
        add(0, 0, 0, 8'h00, 32'h0,        0, 0, 0);
        add(1, 1, 1, 8'h11, 32'h0,        0, 1, 0);
        add(1, 1, 0, 8'h22, 32'h0,        0, 1, 0);
        add(1, 1, 0, 8'h33, 32'h0,        0, 1, 0);
        add(1, 1, 0, 8'h44, 32'h44332211, 1, 1, 0);
        add(1, 0, 0, 8'h99, 32'h44332211, 0, 1, 0);
        // Early sync
        add(1, 1, 1, 8'h11, 32'h44332211, 0, 1, 0);
        add(1, 1, 0, 8'h22, 32'h44332211, 0, 1, 0);
        add(1, 1, 1, 8'hAA, 32'h44332211, 0, 1, 1);
        add(1, 1, 0, 8'hBB, 32'h44332211, 0, 1, 0);
        add(1, 1, 0, 8'hCC, 32'h44332211, 0, 1, 0);
        add(1, 1, 0, 8'hDD, 32'hDDCCBBAA, 1, 1, 0);
        // Missing sync, ignored strobes, relock
        add(1, 1, 0, 8'h55, 32'hDDCCBBAA, 0, 0, 1);
        add(1, 1, 0, 8'h66, 32'hDDCCBBAA, 0, 0, 0);
        add(1, 1, 0, 8'h77, 32'hDDCCBBAA, 0, 0, 0);
        add(1, 1, 1, 8'h01, 32'hDDCCBBAA, 0, 1, 0);
        add(1, 1, 0, 8'h02, 32'hDDCCBBAA, 0, 1, 0);
        add(1, 1, 0, 8'h03, 32'hDDCCBBAA, 0, 1, 0);
        add(1, 1, 0, 8'h04, 32'h04030201, 1, 1, 0);
        // Reset mid-frame (rst_n wins over en)
        add(1, 1, 1, 8'h11, 32'h04030201, 0, 1, 0);
        add(1, 1, 0, 8'h22, 32'h04030201, 0, 1, 0);
        add(0, 1, 0, 8'h33, 32'h0,        0, 0, 0);
        add(1, 1, 0, 8'h44, 32'h0,        0, 0, 0);
        add(1, 1, 1, 8'h0A, 32'h0,        0, 1, 0);
        add(1, 1, 0, 8'h0B, 32'h0,        0, 1, 0);
        add(1, 1, 0, 8'h0C, 32'h0,        0, 1, 0);
        add(1, 1, 0, 8'h0D, 32'h0D0C0B0A, 1, 1, 0);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].e, vecs[i].s, vecs[i].d);
            chk("vec_dout",   i, dout,              vecs[i].x_dout);
            chk("vec_fv",     i, 32'(frame_valid),  32'(vecs[i].x_fv));
            chk("vec_locked", i, 32'(locked),       32'(vecs[i].x_lk));
            chk("vec_err",    i, 32'(sync_err),     32'(vecs[i].x_err));
        end

        // Gapped frame: 0-3 idle cycles between strobes
        step(0, 0, 0, 8'h00);
        chk_model(1000);
        for (int k = 0; k < N_CH; k++) begin
            step(1, 1, (k == 0), 8'((k + 1) * 8'h11));
            chk_model(1100 + k);
            for (int g = 0; g < k; g++) begin
                step(1, 0, 0, 8'hFF);
                chk_model(1200 + k * 4 + g);
            end
        end
        chk("gap_dout", 0, dout, 32'h44332211);

        // Back-to-back: 3 frames, frame_valid on every 4th cycle
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N_CH; k++) begin
                step(1, 1, (k == 0), 8'(f * 16 + k + 1));
                chk_model(1300 + f * 4 + k);
                chk("b2b_fv", f * 4 + k, 32'(frame_valid), 32'(k == N_CH - 1));
            end
        end

        // Randomized traffic against the reference model
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            logic r, e, s, want;
            r    = ($urandom_range(0, 199) != 0);
            e    = ($urandom_range(0, 9) < 7);
            want = !m_locked ? ($urandom_range(0, 2) == 0) : (m_q.size() == 0);
            s    = ($urandom_range(0, 24) == 0) ? !want : want;
            step(r, e, s, 8'($urandom));
            chk_model(2000 + i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
